wave_playback_ctrl: RTL and testbench
=====================================

// Module: wave_playback_ctrl
// PURPOSE
//  Playback sequencer for the shared waveform sample ROM (16-bit words, 1-cycle synchronous read).
//  On start it walks the address range of one selected waveform at a programmable sample rate.
//  Each word's upper byte is emitted to the DAC/PWM path as an 8-bit sample with a valid strobe.
//  Supports one-shot playback (done pulse) and looped playback (runs until stop).
// PARAMETERS
//  ADDR_W    10  ROM address width
//  DATA_W    16  ROM word width
//  OUT_W      8  sample width; sample = rom_data[DATA_W-1 -: OUT_W]
//  NUM_WAVES  4  waveforms in the table (wave_sel width = $clog2(NUM_WAVES))
//  DIV_W     16  sample-rate divider width
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  start        in   1       start playback; sampled only in IDLE
//  stop         in   1       abort playback; dominates start
//  wave_sel     in   2       waveform index, latched at start
//  loop_mode    in   1       1 = wrap and repeat, 0 = one-shot; latched at start
//  rate_div     in   DIV_W   sample period = rate_div+1 clocks; latched at start
//  rom_en       out  1       ROM read enable
//  rom_addr     out  ADDR_W  ROM read address
//  rom_data     in   DATA_W  ROM read data, valid 1 clock after rom_en
//  sample_out   out  OUT_W   current sample; holds between strobes
//  sample_valid out  1       1-clock strobe per new sample
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-clock pulse at end of one-shot playback
// BEHAVIOUR
//  Reset: state=IDLE; rom_en, rom_addr, sample_out, sample_valid, busy, done all 0; pending reads dropped.
//  FSM states:
//   IDLE  -> RUN on start && !stop: latch wave_sel/loop_mode/rate_div; addr=WAVE_BASE[sel]; div_cnt=0.
//   RUN   -> issue reads on prescaler ticks; last address in one-shot -> DRAIN.
//   DRAIN -> IDLE once the final read's sample has been emitted.
//  Prescaler: div_cnt counts 0..rate_div_l; a tick occurs when div_cnt==0.
//   The first tick is the first RUN clock; rate_div=0 gives a tick every clock.
//  On tick: rom_en=1 for 1 clock with rom_addr=addr; addr then advances.
//   Advance: addr+1, or, at WAVE_BASE+WAVE_LEN-1, wrap to WAVE_BASE (loop) / DRAIN (one-shot).
//  Pipeline: rom_en at edge N -> rom_data valid during N+1 -> sample_out/sample_valid registered at N+2.
//   Start sampled at edge E0 -> rom_en/base addr at E1 -> first sample_valid at E3.
//  Outside tick cycles: rom_en=0; rom_addr holds its last value.
//  done asserts in the same clock as the last one-shot sample_valid; busy falls the following clock.
//  WAVE_LEN=1 in loop mode re-reads the same address every period.
//  Period vs. latency: valid strobes are spaced exactly rate_div+1 clocks, because a new read can issue every clock.
//  stop while busy: next edge -> IDLE, rom_en=0; no further sample_valid, no done.
//   An in-flight read is discarded; sample_out keeps its last emitted value.
//  start while busy: ignored. start&&stop in IDLE: ignored.
//  Changes to inputs after start have no effect until the next start.
//  rst mid-playback: as reset, applied at that edge.
//  Address arithmetic is ADDR_W bits; table entries satisfy BASE+LEN <= 2**ADDR_W (elaboration check).
// STRUCTURE
//  wave_ctrl_pkg (shared): WAVE_BASE/WAVE_LEN tables and FSM state encodings.
//   Tables: 0 sine 0/256, 1 square 256/2, 2 triangle 512/256, 3 decay 768/3.
//  Sub-module rate_prescaler: DIV_W counter with load/clear and tick output, reused by other generators.
// TESTING
//  1 Reset: assert rst 2 clks during RUN (loop sine) -> all outputs 0 next edge, busy=0, no further valid.
//  2 One-shot decay: sel=3, div=0, start -> rom_addr 768,769,770 on consecutive clks.
//     Then valid on 3 consecutive clks starting E3; done with the 3rd valid; busy=0 next clk.
//  3 Loop square: sel=1, div=4 -> valid every 5 clks, addr 256,257,256,257...
//     20 samples checked against the ROM model, done never asserted.
//  4 Stop mid-run: loop triangle div=2, stop after 7th valid -> no valid from stop+1, no done, busy=0 at stop+1.
//  5 Ignored starts: start pulse while busy -> sequence unchanged; start&&stop in IDLE -> busy stays 0.
//  6 Latching: change rate_div/wave_sel during run -> period and addresses unchanged until next start.

Source files
------------

// File: rtl/wave_playback_ctrl_pkg.sv
// wave_ctrl_pkg: waveform table shared by the playback sequencer and the other
// generators that read the same sample ROM, plus the sequencer state encoding.
//   WAVE_BASE / WAVE_LEN : first ROM word and word count of each waveform
//   state_t              : playback FSM states
//   table_fits()         : true when every table entry lies inside the ROM
package wave_ctrl_pkg;

  localparam int unsigned TABLE_WAVES = 4;

  // 0 sine, 1 square, 2 triangle, 3 decay
  localparam int unsigned WAVE_BASE [TABLE_WAVES] = '{0, 256, 512, 768};
  localparam int unsigned WAVE_LEN  [TABLE_WAVES] = '{256, 2, 256, 3};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic bit table_fits(input int unsigned addr_w);
    for (int unsigned i = 0; i < TABLE_WAVES; i++) begin
      if (WAVE_LEN[i] == 0) return 1'b0;
      if (WAVE_BASE[i] + WAVE_LEN[i] > (32'd1 << addr_w)) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/wave_playback_ctrl_if.sv
// ROM read bus between the playback sequencer and the waveform sample ROM.
//   rom_en   : read enable (master -> ROM)
//   rom_addr : read address (master -> ROM)
//   rom_data : read word, valid one clock after rom_en (ROM -> master)
interface wave_playback_ctrl_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) ();
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_en, output rom_addr, input  rom_data);
  modport slave  (input  rom_en, input  rom_addr, output rom_data);
endinterface

// File: rtl/wave_playback_ctrl_rate_prescaler.sv
// rate_prescaler: programmable tick generator.
//   clk, rst  : clock, synchronous active-high reset
//   load      : latch load_val as the terminal count and restart at 0
//   en        : count enable
//   load_val  : terminal count; tick period = load_val+1 clocks
//   tick      : high while enabled and the count is 0
module rate_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      limit <= '0;
      cnt   <= '0;
    end else if (load) begin
      limit <= load_val;
      cnt   <= '0;
    end else if (en) begin
      cnt <= (cnt == limit) ? '0 : cnt + 1'b1;
    end
  end

  always_comb tick = en && (cnt == '0);
endmodule

// File: rtl/wave_playback_ctrl.sv
// wave_playback_ctrl: walks one waveform of the sample ROM at a programmable
// rate and emits the upper byte of each word as a sample strobe.
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : begin playback (IDLE only) / abort (dominates start)
//   wave_sel     : waveform index, latched at start
//   loop_mode    : 1 = repeat until stop, 0 = one-shot; latched at start
//   rate_div     : sample period = rate_div+1 clocks; latched at start
//   rom          : ROM read bus (rom_en, rom_addr out; rom_data in)
//   sample_out   : last emitted sample, held between strobes
//   sample_valid : 1-clock strobe per new sample
//   busy         : high whenever not IDLE
//   done         : 1-clock pulse with the last one-shot sample
module wave_playback_ctrl
  import wave_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned NUM_WAVES = 4,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic [$clog2(NUM_WAVES)-1:0] wave_sel,
  input  logic                         loop_mode,
  input  logic [DIV_W-1:0]             rate_div,
  wave_playback_ctrl_if.master         rom,
  output logic [OUT_W-1:0]             sample_out,
  output logic                         sample_valid,
  output logic                         busy,
  output logic                         done
);

  if (!table_fits(ADDR_W) || NUM_WAVES > TABLE_WAVES) begin : g_table_check
    $error("wave table does not fit the ROM address range");
  end

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base_l;
  logic [ADDR_W-1:0] last_l;
  logic              loop_l;
  logic              rd_pend;   // rom_data holds the word requested last clock
  logic              tick;
  logic              abort;
  logic              launch;
  logic [ADDR_W-1:0] base_sel;
  logic [ADDR_W-1:0] last_sel;

  always_comb begin
    base_sel = ADDR_W'(WAVE_BASE[wave_sel]);
    last_sel = ADDR_W'(WAVE_BASE[wave_sel] + WAVE_LEN[wave_sel] - 1);
    abort    = stop && (state != ST_IDLE);
    launch   = (state == ST_IDLE) && start && !stop;
  end

  rate_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (launch),
    .en       (state == ST_RUN),
    .load_val (rate_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr         <= '0;
      base_l       <= '0;
      last_l       <= '0;
      loop_l       <= 1'b0;
      rd_pend      <= 1'b0;
      rom.rom_en   <= 1'b0;
      rom.rom_addr <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rom.rom_en   <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      // A stop discards both the read issued last clock and the word now on rom_data.
      rd_pend      <= rom.rom_en && !abort;
      if (rd_pend && !abort) begin
        sample_out   <= rom.rom_data[DATA_W-1 -: OUT_W];
        sample_valid <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            state  <= ST_RUN;
            busy   <= 1'b1;
            addr   <= base_sel;
            base_l <= base_sel;
            last_l <= last_sel;
            loop_l <= loop_mode;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tick) begin
            rom.rom_en   <= 1'b1;
            rom.rom_addr <= addr;
            if (addr == last_l) begin
              if (loop_l) addr  <= base_l;
              else        state <= ST_DRAIN;
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // The final read is the only one left once rom_en has dropped, so the
          // word arriving then is the last sample; busy drops one clock later.
          if (stop || done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (rd_pend && !rom.rom_en) begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_playback_ctrl.sv
// Scoreboard bench for wave_playback_ctrl: each playback request pushes the
// expected ROM reads and samples (with the clock they must appear on) into
// queues; negedge monitors pop and compare whatever the DUT presents.
module tb_wave_playback_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop_mode;
  logic [1:0]  wave_sel;
  logic [15:0] rate_div;
  logic [7:0]  sample_out;
  logic        sample_valid, busy, done;

  wave_playback_ctrl_if #(.ADDR_W(10), .DATA_W(16)) rom_bus ();

  wave_playback_ctrl #(
    .ADDR_W(10), .DATA_W(16), .OUT_W(8), .NUM_WAVES(4), .DIV_W(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .wave_sel     (wave_sel),
    .loop_mode    (loop_mode),
    .rate_div     (rate_div),
    .rom          (rom_bus.master),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Waveform table and ROM contents as the bench understands them.
  int          tb_base [4] = '{0, 256, 512, 768};
  int          tb_len  [4] = '{256, 2, 256, 3};
  logic [15:0] mem [1024];

  always @(posedge clk)
    if (rom_bus.rom_en === 1'b1) rom_bus.rom_data <= mem[rom_bus.rom_addr];

  typedef struct { int c; logic [7:0] s; bit d; } smp_e;
  typedef struct { int c; logic [9:0] a; } addr_e;
  smp_e sq[$];
  addr_e aq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Sample / done monitor
  always @(negedge clk) begin
    smp_e e;
    while (sq.size() > 0 && sq[0].c < cyc) begin
      chk("sample_missing_cycle", cyc, sq[0].c);
      void'(sq.pop_front());
    end
    if (sample_valid === 1'b1) begin
      if (sq.size() > 0 && sq[0].c == cyc) begin
        e = sq.pop_front();
        chk("sample_value", sample_out, e.s);
        chk("done_with_sample", done, e.d);
      end else begin
        chk("unexpected_valid_cycle", cyc, (sq.size() > 0) ? sq[0].c : -1);
      end
    end else begin
      chk("valid_low", sample_valid, 1'b0);
      chk("done_without_sample", done, 1'b0);
    end
  end

  // ROM read monitor
  always @(negedge clk) begin
    addr_e e;
    while (aq.size() > 0 && aq[0].c < cyc) begin
      chk("read_missing_cycle", cyc, aq[0].c);
      void'(aq.pop_front());
    end
    if (rom_bus.rom_en === 1'b1) begin
      if (aq.size() > 0 && aq[0].c == cyc) begin
        e = aq.pop_front();
        chk("rom_addr", rom_bus.rom_addr, e.a);
      end else begin
        chk("unexpected_read_cycle", cyc, (aq.size() > 0) ? aq[0].c : -1);
      end
    end
  end

  // Called 1 time unit after an edge; returns 1 time unit after edge c.
  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One playback. Loop runs are ended by stop (or rst) right after sample n_loop.
  task automatic play(input int sel, input bit lp, input int div, input int n_loop,
                      input bit use_rst, input bit disturb);
    int e0, p, n, s_edge, d_edge, a;
    logic [7:0] last_s;
    p      = div + 1;
    e0     = cyc + 1;
    n      = lp ? n_loop : tb_len[sel];
    s_edge = lp ? e0 + 3 + (n - 1) * p + 1 : 32'h3fff_ffff;
    wave_sel  = 2'(sel);
    loop_mode = lp;
    rate_div  = 16'(div);
    start     = 1'b1;
    for (int i = 0; (e0 + 1 + i * p < s_edge) && (lp || i < n); i++)
      aq.push_back('{e0 + 1 + i * p, 10'(tb_base[sel] + i % tb_len[sel])});
    last_s = '0;
    for (int i = 0; i < n; i++) begin
      a = tb_base[sel] + i % tb_len[sel];
      last_s = mem[a][15:8];
      sq.push_back('{e0 + 3 + i * p, last_s, !lp && (i == n - 1)});
    end
    wait_to(e0);
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    if (disturb) begin
      wait_to(e0 + 3);
      start     = 1'b1;
      wave_sel  = 2'(sel ^ 2);
      rate_div  = 16'(div + 5);
      loop_mode = !lp;
      wait_to(e0 + 4);
      start = 1'b0;
    end
    if (lp) begin
      wait_to(s_edge - 1);
      if (use_rst) rst = 1'b1;
      else         stop = 1'b1;
      wait_to(s_edge);
      chk("busy_after_abort", busy, 1'b0);
      chk("rom_en_after_abort", rom_bus.rom_en, 1'b0);
      chk("sample_out_after_abort", sample_out, use_rst ? 8'h00 : last_s);
      if (use_rst) begin
        chk("rom_addr_after_rst", rom_bus.rom_addr, 10'd0);
        wait_to(s_edge + 1);
      end
      rst  = 1'b0;
      stop = 1'b0;
      wait_to(cyc + 4);
      chk("busy_stays_low", busy, 1'b0);
    end else begin
      d_edge = e0 + 3 + (n - 1) * p;
      wait_to(d_edge);
      chk("busy_at_done", busy, 1'b1);
      chk("done_pulse", done, 1'b1);
      wait_to(d_edge + 1);
      chk("busy_after_done", busy, 1'b0);
      chk("sample_held", sample_out, last_s);
    end
    chk("queues_drained", sq.size() + aq.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_mode = 1'b0;
    wave_sel = '0; rate_div = '0;
    @(posedge clk);
    #1;
    wait_to(3);
    chk("reset_rom_en", rom_bus.rom_en, 1'b0);
    chk("reset_rom_addr", rom_bus.rom_addr, 10'd0);
    chk("reset_sample_out", sample_out, 8'h00);
    chk("reset_sample_valid", sample_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    wait_to(cyc + 2);

    play(3, 1'b0, 0, 0, 1'b0, 1'b0);   // one-shot decay, back-to-back reads
    play(1, 1'b1, 4, 20, 1'b0, 1'b0);  // looped square, 20 samples then stop
    play(2, 1'b1, 2, 7, 1'b0, 1'b0);   // looped triangle, stop after 7th sample
    play(3, 1'b0, 3, 0, 1'b0, 1'b1);   // start/inputs changed mid-run are ignored
    play(1, 1'b1, 1, 9, 1'b0, 1'b1);

    c = cyc;                            // start with stop in IDLE
    start = 1'b1;
    stop  = 1'b1;
    wait_to(c + 1);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle_busy", busy, 1'b0);
    wait_to(c + 3);
    chk("start_stop_idle_busy_later", busy, 1'b0);

    play(0, 1'b1, 1, 10, 1'b1, 1'b0);  // rst during looped sine
    play(3, 1'b0, 0, 0, 1'b0, 1'b0);   // clean restart after rst

    for (int k = 0; k < 6; k++)
      play($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 5),
           $urandom_range(1, 12), 1'b0, 1'b0);

    wait_to(cyc + 5);
    chk("final_queues_empty", sq.size() + aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
